// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the line levels used by both receiver and the later transmitter.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    localparam logic LINE_IDLE_LVL  = 1'b1;
    localparam logic START_BIT_LVL  = 1'b0;
    localparam logic STOP_BIT_LVL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to RESET_VAL so an idle-high line never looks like an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data
// capture, stop-bit check with framing-error recovery after a held-low break.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
    logic                   rx_s;

    sync_2ff #(
        .RESET_VAL (LINE_IDLE_LVL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Everything advances only on oversample ticks; the pulse flags self-clear.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (sample_enable) begin
            case (state_q)
                IDLE: begin
                    if (rx_s == START_BIT_LVL) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rx_s == START_BIT_LVL) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s == STOP_BIT_LVL) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s == LINE_IDLE_LVL) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick generator divides clk by 8 (128 clk per bit),
// frames are driven on the falling clock edge and outputs sampled there too.
module tb_uart_rx;

    localparam int DIV     = 8;
    localparam int BIT_CLK = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_enable = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         div_cnt  = 0;
    int         ferr_n   = 0;
    int         both_n   = 0;
    int         valid_cyc = 0;
    int         start_cyc = 0;
    logic [7:0] rx_log[$];

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_enable (sample_enable),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the baud rate generator: one tick every DIV clocks.
    always @(posedge clk) begin
        cyc           <= cyc + 1;
        div_cnt       <= (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
        sample_enable <= (div_cnt == DIV - 1);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log.push_back(rx_data);
            valid_cyc <= cyc;
        end
        if (frame_error) ferr_n <= ferr_n + 1;
        if (rx_valid && frame_error) both_n <= both_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic line(input logic lvl, input int nclk);
        rx = lvl;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int p);
        start_cyc = cyc;
        line(1'b0, p);
        for (int i = 0; i < 8; i++) line(d[i], p);
        line(stop_lvl, p);
    endtask

    int         nv0, nf0;
    int         lat;
    logic [7:0] exp_q[$];
    logic [7:0] byte_v;
    int         per;

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_eq("rst_rx_data", 32'(rx_data), 32'h0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_frame_error", 32'(frame_error), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        line(1'b1, 3 * BIT_CLK);

        // 0x55 with good stop bit, latency about 9.5 bits from the start edge
        nv0 = rx_log.size(); nf0 = ferr_n;
        send_frame(8'h55, 1'b1, BIT_CLK);
        line(1'b1, 2 * BIT_CLK);
        check_eq("f55_valid_count", 32'(rx_log.size() - nv0), 32'd1);
        if (rx_log.size() > nv0) check_eq("f55_data", 32'(rx_log[nv0]), 32'h55);
        check_eq("f55_rx_data", 32'(rx_data), 32'h55);
        check_eq("f55_ferr", 32'(ferr_n - nf0), 32'd0);
        lat = valid_cyc - start_cyc;
        check_eq("f55_latency_in_1215_1230", 32'((lat >= 1215) && (lat <= 1230)), 32'd1);

        // Three-tick glitch is rejected
        nv0 = rx_log.size(); nf0 = ferr_n;
        line(1'b0, 3 * DIV);
        line(1'b1, 300);
        check_eq("glitch_valid", 32'(rx_log.size() - nv0), 32'd0);
        check_eq("glitch_ferr", 32'(ferr_n - nf0), 32'd0);
        check_eq("glitch_rx_data", 32'(rx_data), 32'h55);
        check_eq("glitch_busy", 32'(busy), 32'd0);

        // 0xA3 with low stop bit, line held low for 40 more bits
        nv0 = rx_log.size(); nf0 = ferr_n;
        start_cyc = cyc;
        line(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) line(byte_v_bit(8'hA3, i), BIT_CLK);
        line(1'b0, 41 * BIT_CLK);
        check_eq("brk_busy_held", 32'(busy), 32'd1);
        check_eq("brk_ferr_count", 32'(ferr_n - nf0), 32'd1);
        check_eq("brk_valid", 32'(rx_log.size() - nv0), 32'd0);
        check_eq("brk_rx_data", 32'(rx_data), 32'h55);
        line(1'b1, 4 * DIV);
        check_eq("brk_busy_released", 32'(busy), 32'd0);
        check_eq("brk_ferr_final", 32'(ferr_n - nf0), 32'd1);
        line(1'b1, 2 * BIT_CLK);

        // Back-to-back 0x00 then 0xFF
        nv0 = rx_log.size(); nf0 = ferr_n;
        send_frame(8'h00, 1'b1, BIT_CLK);
        send_frame(8'hFF, 1'b1, BIT_CLK);
        line(1'b1, 2 * BIT_CLK);
        check_eq("b2b_valid_count", 32'(rx_log.size() - nv0), 32'd2);
        if (rx_log.size() >= nv0 + 2) begin
            check_eq("b2b_first", 32'(rx_log[nv0]), 32'h00);
            check_eq("b2b_second", 32'(rx_log[nv0 + 1]), 32'hFF);
        end
        check_eq("b2b_ferr", 32'(ferr_n - nf0), 32'd0);

        // Reset during bit 4 of 0x3C, released in its stop bit, then 0x81
        nv0 = rx_log.size(); nf0 = ferr_n;
        line(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) line(byte_v_bit(8'h3C, i), BIT_CLK);
        line(byte_v_bit(8'h3C, 4), BIT_CLK / 2);
        rst = 1'b0;
        line(byte_v_bit(8'h3C, 4), 2);
        check_eq("mrst_rx_data", 32'(rx_data), 32'h0);
        check_eq("mrst_rx_valid", 32'(rx_valid), 32'h0);
        check_eq("mrst_frame_error", 32'(frame_error), 32'h0);
        check_eq("mrst_busy", 32'(busy), 32'h0);
        line(byte_v_bit(8'h3C, 4), BIT_CLK / 2 - 2);
        for (int i = 5; i < 8; i++) line(byte_v_bit(8'h3C, i), BIT_CLK);
        line(1'b1, BIT_CLK / 2);
        rst = 1'b1;
        line(1'b1, BIT_CLK / 2 + 2 * BIT_CLK);
        check_eq("mrst_no_output", 32'(rx_log.size() - nv0), 32'd0);
        check_eq("mrst_no_ferr", 32'(ferr_n - nf0), 32'd0);
        send_frame(8'h81, 1'b1, BIT_CLK);
        line(1'b1, 2 * BIT_CLK);
        check_eq("mrst_81_count", 32'(rx_log.size() - nv0), 32'd1);
        check_eq("mrst_81_data", 32'(rx_data), 32'h81);

        // Random back-to-back stream at -2%, 0% and +2% bit rate
        nv0 = rx_log.size(); nf0 = ferr_n;
        for (int f = 0; f < 40; f++) begin
            byte_v = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       per = 125;
                1:       per = 128;
                default: per = 131;
            endcase
            exp_q.push_back(byte_v);
            send_frame(byte_v, 1'b1, per);
        end
        line(1'b1, 3 * BIT_CLK);
        check_eq("rnd_count", 32'(rx_log.size() - nv0), 32'd40);
        if (rx_log.size() - nv0 == 40) begin
            for (int i = 0; i < 40; i++)
                check_eq($sformatf("rnd_byte_%0d", i), 32'(rx_log[nv0 + i]), 32'(exp_q[i]));
        end
        check_eq("rnd_ferr", 32'(ferr_n - nf0), 32'd0);
        check_eq("never_both_pulses", 32'(both_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic byte_v_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule : tb_uart_rx
